bram_rdata_fifo: RTL and testbench

Output buffer directly downstream of bram_controller. It captures the controller's read-back stream (o_valid / o_mem_data), which cannot be stalled. It then presents the words to a consumer over a valid/ready handshake. It is a first-word-fall-through synchronous FIFO with almost-full, a sticky overflow flag and an occupancy count.

---
 rtl/bram_rdata_fifo.sv | 66 ++++++
 tb/tb_bram_rdata_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bram_rdata_fifo.sv
// bram_rdata_fifo: first-word-fall-through buffer for the non-stallable bram_controller read-back stream
// Define FIFO_PEAK_EN to turn o_peak into a high-water mark register; otherwise it is tied to 0.
module bram_rdata_fifo #(
  parameter int DWIDTH      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_AWIDTH = 4,
  parameter int AFULL_TH    = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  input  logic [DWIDTH-1:0]      i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DWIDTH-1:0]      o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_afull,
  output logic [FIFO_AWIDTH:0]   o_count,
  output logic                   o_overflow,
  input  logic                   i_clr_ovf,
  output logic [FIFO_AWIDTH:0]   o_peak
);
  localparam logic [FIFO_AWIDTH:0] LP_DEPTH = (FIFO_AWIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AWIDTH:0] LP_AFULL = (FIFO_AWIDTH+1)'(AFULL_TH);
  localparam logic [FIFO_AWIDTH:0] LP_ONE   = (FIFO_AWIDTH+1)'(1);
  logic [DWIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AWIDTH:0]   r_count;
  logic                   r_overflow;
  logic                   w_push, w_pop, w_drop;
  assign o_empty    = r_count == '0;
  assign o_full     = r_count == LP_DEPTH;
  assign o_afull    = r_count >= LP_AFULL;
  assign o_valid    = !o_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_data     = r_mem[r_rd_ptr];
  assign w_pop      = o_valid && i_ready;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign w_push     = i_valid && (!o_full || w_pop);
  assign w_drop     = i_valid && o_full && !w_pop;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AWIDTH'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AWIDTH'(1);
      if (w_push != w_pop) r_count <= w_push ? r_count + LP_ONE : r_count - LP_ONE;
      r_overflow <= w_drop || (r_overflow && !i_clr_ovf);
    end
`ifdef FIFO_PEAK_EN
  logic [FIFO_AWIDTH:0] r_peak;
  assign o_peak = r_peak;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_peak <= '0;
    else if (i_clr_ovf || r_count > r_peak) r_peak <= r_count;
`else
  assign o_peak = '0;
`endif
endmodule

// File: tb/tb_bram_rdata_fifo.sv
// tb_bram_rdata_fifo: directed checks of bram_rdata_fifo ordering, flags, overflow and reset
module tb_bram_rdata_fifo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0, i_ready = 1'b0, i_clr_ovf = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_valid, o_full, o_empty, o_afull, o_overflow;
  logic [15:0] o_data;
  logic [4:0]  o_count, o_peak;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] last;
  logic        m_ovf = 1'b0;
  int          m_peak = 0;

  bram_rdata_fifo dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_full(o_full),
    .o_empty(o_empty), .o_afull(o_afull), .o_count(o_count),
    .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .o_peak(o_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_empty"}, o_empty, 1);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_full"}, o_full, 0);
    chk({tag, "_afull"}, o_afull, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    chk({tag, "_peak"}, o_peak, 0);
  endtask

  // one clock: apply inputs, check head against model, advance, check state
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
    int n;
    logic pop, push, drop;
    i_valid = v; i_data = d; i_ready = r; i_clr_ovf = c;
    n = q.size();
    pop = n > 0 && r;
    push = v && (n < 16 || pop);
    drop = v && n == 16 && !pop;
    chk("valid", o_valid, n > 0);
    if (pop) begin
      chk("data", o_data, q[0]);
      last = q.pop_front();
    end
    if (push) q.push_back(d);
    m_ovf = drop || (m_ovf && !c);
`ifdef FIFO_PEAK_EN
    if (c || n > m_peak) m_peak = n;
`endif
    @(posedge clk); #1;
    chk("count", o_count, q.size());
    chk("full", o_full, q.size() == 16);
    chk("empty", o_empty, q.size() == 0);
    chk("afull", o_afull, q.size() >= 12);
    chk("ovf", o_overflow, m_ovf);
    chk("peak", o_peak, m_peak);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step(0, 16'h0, 1, 0);
    chk("drained", o_empty, 1);
  endtask

  initial begin
    // 1: reset with random traffic
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'($urandom_range(0, 1)); i_ready = 1'($urandom_range(0, 1));
      i_data = 16'($urandom);
      @(posedge clk); #1;
      reset_vals("rst");
    end
    i_valid = 0; i_ready = 0; reset_n = 1'b1;
    @(posedge clk); #1;
    reset_vals("post_rst");

    // 2: streaming, first word visible one cycle after push
    step(1, 16'd0, 1, 0);
    chk("first_valid", o_valid, 1);
    chk("first_data", o_data, 16'd0);
    for (int k = 1; k < 100; k++) begin
      step(1, 16'(k), 1, 0);
      chk("stream_le1", o_count <= 5'd1, 1);
    end
    step(0, 16'h0, 1, 0);
    chk("stream_last", last, 16'd99);
`ifdef FIFO_PEAK_EN
    chk("stream_peak", o_peak, 1);
`endif

    // 3: fill, almost-full, full, dropped write, drain
    for (int k = 0; k < 16; k++) begin
      step(1, 16'h0010 + 16'(k), 0, 0);
      if (k == 10) chk("afull_11", o_afull, 0);
      if (k == 11) chk("afull_12", o_afull, 1);
      if (k == 14) chk("full_15", o_full, 0);
    end
    chk("full_16", o_full, 1);
    step(1, 16'hDEAD, 0, 0);
    chk("drop_ovf", o_overflow, 1);
    chk("drop_cnt", o_count, 16);
    drain();
    chk("fill_last", last, 16'h001F);
    step(0, 16'h0, 0, 1);
    chk("clr_ovf", o_overflow, 0);

    // 4: push+pop while full
    for (int k = 0; k < 16; k++) step(1, 16'h0030 + 16'(k), 0, 0);
    step(1, 16'h0100, 1, 0);
    chk("pp_cnt", o_count, 16);
    chk("pp_ovf", o_overflow, 0);
    drain();
    chk("pp_last", last, 16'h0100);

    // 5: wrap-around with ready pattern 1,0,0
    begin
      int pushed = 0, cyc = 0;
      while (pushed < 40 && cyc < 200) begin
        logic r;
        r = (cyc % 3) == 0;
        if (q.size() < 16 || r) begin
          step(1, 16'h0200 + 16'(pushed), r, 0);
          pushed++;
        end else step(0, 16'h0, r, 0);
        cyc++;
      end
      chk("wrap_pushed", pushed, 40);
    end
    drain();
    chk("wrap_last", last, 16'h0227);
    chk("wrap_ovf", o_overflow, 0);

    // 6: set beats clear, clear alone, async reset at count 7
    for (int k = 0; k < 16; k++) step(1, 16'h0300 + 16'(k), 0, 0);
    step(1, 16'hBEEF, 0, 1);
    chk("set_wins", o_overflow, 1);
    step(0, 16'h0, 0, 1);
    chk("clr_alone", o_overflow, 0);
    for (int k = 0; k < 9; k++) step(0, 16'h0, 1, 0);
    chk("pre_rst_cnt", o_count, 7);
    i_valid = 1; i_ready = 0;
    #2 reset_n = 1'b0;
    #1 reset_vals("async_rst");
    @(posedge clk); #1;
    reset_vals("held_rst");
    i_valid = 0; reset_n = 1'b1;
    q.delete(); m_ovf = 0; m_peak = 0;
    step(0, 16'h0, 0, 0);
    step(1, 16'h0AAA, 0, 0);
    step(0, 16'h0, 1, 0);
    chk("after_rst", last, 16'h0AAA);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
